spi_cmd_image_loader: RTL and testbench

Command parser directly downstream of the SPI peripheral byte interface. Consumes received bytes, decodes a small command set, streams a 32x32 binary image (128 packed bytes) into the image buffer, and launches inference. Drives the status byte that the SPI peripheral shifts back on CIPO. Sits between the SPI front-end and the BNN core / image RAM.

---
 rtl/spi_cmd_image_loader_if.sv | 29 ++
 rtl/spi_cmd_image_loader.sv | 194 +++++++++++++++++++
 tb/tb_spi_cmd_image_loader.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_image_loader_if.sv
// Byte, image-buffer and inference signals between the SPI front-end, the
// command loader, the image RAM and the BNN core.
interface spi_cmd_image_loader_if #(
  parameter int ADDR_W = 7
) ();
  logic [7:0]        rx_byte;
  logic              byte_valid;
  logic              spi_error;
  logic [7:0]        tx_byte;
  logic              img_wr_en;
  logic [ADDR_W-1:0] img_wr_addr;
  logic [7:0]        img_wr_data;
  logic              img_loaded;
  logic              start_infer;
  logic              infer_busy;
  logic              infer_done;
  logic [3:0]        result_class;

  // The loader is the slave; the surrounding system (SPI, RAM, core) is the master.
  modport slave (
    input  rx_byte, byte_valid, spi_error, infer_busy, infer_done, result_class,
    output tx_byte, img_wr_en, img_wr_addr, img_wr_data, img_loaded, start_infer
  );

  modport master (
    output rx_byte, byte_valid, spi_error, infer_busy, infer_done, result_class,
    input  tx_byte, img_wr_en, img_wr_addr, img_wr_data, img_loaded, start_infer
  );
endinterface

// File: rtl/spi_cmd_image_loader.sv
// SPI command parser: decodes load/start/clear opcodes, streams the packed image
// into the buffer and reports status. Define CHECKSUM_EN to require an XOR checksum byte.
module spi_cmd_image_loader #(
  parameter int         IMG_BYTES = 128,
  parameter int         ADDR_W    = 7,
  parameter logic [7:0] CMD_LOAD  = 8'hA1,
  parameter logic [7:0] CMD_START = 8'hA2,
  parameter logic [7:0] CMD_CLEAR = 8'hA3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_cmd_image_loader_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMG_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
`ifdef CHECKSUM_EN
    LOAD,
    LOAD_CSUM
`else
    LOAD
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              bv_prev_q;
  logic              cmd_error_q, cmd_error_d;
  logic              result_valid_q, result_valid_d;
  logic [3:0]        result_q, result_d;
  logic              img_loaded_q, img_loaded_d;
  logic              start_q, start_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [7:0]        tx_q;
`ifdef CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  // Only the rising edge of byte_valid delivers a byte.
  logic accept;
  assign accept = bus.byte_valid & ~bv_prev_q;

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    cmd_error_d    = cmd_error_q;
    result_valid_d = result_valid_q;
    result_d       = result_q;
    img_loaded_d   = img_loaded_q;
    start_d        = 1'b0;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
`ifdef CHECKSUM_EN
    csum_d         = csum_q;
`endif

    // Evaluated first so an accepted START in the same cycle overrides it.
    if (bus.infer_done) begin
      result_d       = bus.result_class;
      result_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.rx_byte == CMD_LOAD) begin
            if (bus.infer_busy) begin
              cmd_error_d = 1'b1;
            end else begin
              img_loaded_d = 1'b0;
              count_d      = '0;
              state_d      = LOAD;
`ifdef CHECKSUM_EN
              csum_d       = 8'h00;
`endif
            end
          end else if (bus.rx_byte == CMD_START) begin
            if (img_loaded_q && !bus.infer_busy) begin
              start_d        = 1'b1;
              result_valid_d = 1'b0;
            end else begin
              cmd_error_d = 1'b1;
            end
          end else if (bus.rx_byte == CMD_CLEAR) begin
            img_loaded_d   = 1'b0;
            result_valid_d = 1'b0;
            cmd_error_d    = 1'b0;
            count_d        = '0;
          end else begin
            cmd_error_d = 1'b1;
          end
        end
        if (bus.spi_error) cmd_error_d = 1'b1;
      end

      LOAD: begin
        if (bus.spi_error) begin
          img_loaded_d = 1'b0;
          cmd_error_d  = 1'b1;
          count_d      = '0;
          state_d      = IDLE;
        end else if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = count_q;
          wr_data_d = bus.rx_byte;
          count_d   = count_q + 1'b1;
`ifdef CHECKSUM_EN
          csum_d    = csum_q ^ bus.rx_byte;
`endif
          if (count_q == LAST_IDX) begin
            count_d = '0;
`ifdef CHECKSUM_EN
            state_d = LOAD_CSUM;
`else
            img_loaded_d = 1'b1;
            state_d      = IDLE;
`endif
          end
        end
      end

`ifdef CHECKSUM_EN
      LOAD_CSUM: begin
        if (bus.spi_error) begin
          img_loaded_d = 1'b0;
          cmd_error_d  = 1'b1;
          count_d      = '0;
          state_d      = IDLE;
        end else if (accept) begin
          if (bus.rx_byte == csum_q) begin
            img_loaded_d = 1'b1;
          end else begin
            img_loaded_d = 1'b0;
            cmd_error_d  = 1'b1;
          end
          state_d = IDLE;
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      count_q        <= '0;
      bv_prev_q      <= 1'b0;
      cmd_error_q    <= 1'b0;
      result_valid_q <= 1'b0;
      result_q       <= 4'h0;
      img_loaded_q   <= 1'b0;
      start_q        <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= 8'h00;
      tx_q           <= 8'h00;
`ifdef CHECKSUM_EN
      csum_q         <= 8'h00;
`endif
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      bv_prev_q      <= bus.byte_valid;
      cmd_error_q    <= cmd_error_d;
      result_valid_q <= result_valid_d;
      result_q       <= result_d;
      img_loaded_q   <= img_loaded_d;
      start_q        <= start_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      // Status snapshot lags the flags by one cycle; busy is sampled live.
      tx_q           <= {img_loaded_q, bus.infer_busy, result_valid_q, cmd_error_q, result_q};
`ifdef CHECKSUM_EN
      csum_q         <= csum_d;
`endif
    end
  end

  assign bus.tx_byte     = tx_q;
  assign bus.img_wr_en   = wr_en_q;
  assign bus.img_wr_addr = wr_addr_q;
  assign bus.img_wr_data = wr_data_q;
  assign bus.img_loaded  = img_loaded_q;
  assign bus.start_infer = start_q;

endmodule

// File: tb/tb_spi_cmd_image_loader.sv
// Self-checking bench for spi_cmd_image_loader: command table, write scoreboard
// and hand-written load/abort/inference sequences.
module tb_spi_cmd_image_loader;

  logic clk;
  logic rst_n;

  spi_cmd_image_loader_if #(.ADDR_W(7)) bus ();

  spi_cmd_image_loader dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_seen = 0;
  int starts = 0;
  logic start_prev = 1'b0;

  logic [14:0] exp_q[$];
  logic [6:0]  wr_addr_exp;
  logic [7:0]  csum;

  typedef struct {
    logic [7:0] op;
    logic       busy;
    logic [7:0] exp_tx;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_byte    = b;
    bus.byte_valid = 1'b1;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic begin_load();
    send(8'hA1);
    wr_addr_exp = 7'd0;
    csum        = 8'h00;
  endtask

  task automatic send_data(input logic [7:0] b);
    exp_q.push_back({wr_addr_exp, b});
    wr_addr_exp = wr_addr_exp + 7'd1;
    csum        = csum ^ b;
    send(b);
  endtask

  task automatic finish_load();
`ifdef CHECKSUM_EN
    send(csum);
`endif
  endtask

  // Scoreboard: every write strobe must match the oldest expected {addr, data}.
  always @(negedge clk) begin
    if (rst_n && bus.img_wr_en) begin
      wr_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                 bus.img_wr_addr, bus.img_wr_data);
      end else begin
        logic [14:0] e;
        e = exp_q.pop_front();
        if ({bus.img_wr_addr, bus.img_wr_data} !== e) begin
          errors++;
          $display("FAIL write: got addr %0h data %0h, expected addr %0h data %0h",
                   bus.img_wr_addr, bus.img_wr_data, e[14:8], e[7:0]);
        end
      end
    end
    if (rst_n && bus.start_infer) begin
      starts++;
      if (start_prev) begin
        checks++;
        errors++;
        $display("FAIL start_width: got start_infer high 2+ cycles, expected 1");
      end
    end
    start_prev = bus.start_infer;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int w0;
    vecs[0] = '{8'hA3, 1'b0, 8'h00};
    vecs[1] = '{8'hA2, 1'b0, 8'h10};
    vecs[2] = '{8'hA3, 1'b0, 8'h00};
    vecs[3] = '{8'h55, 1'b0, 8'h10};
    vecs[4] = '{8'hA3, 1'b0, 8'h00};
    vecs[5] = '{8'hA1, 1'b1, 8'h50};
    vecs[6] = '{8'hA3, 1'b0, 8'h00};

    rst_n            = 1'b0;
    bus.rx_byte      = 8'h00;
    bus.byte_valid   = 1'b0;
    bus.spi_error    = 1'b0;
    bus.infer_busy   = 1'b0;
    bus.infer_done   = 1'b0;
    bus.result_class = 4'h0;
    wr_addr_exp      = 7'd0;
    csum             = 8'h00;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check("reset_tx", bus.tx_byte, 8'h00);
    check("reset_wr_en", bus.img_wr_en, 1'b0);
    check("reset_loaded", bus.img_loaded, 1'b0);
    check("reset_start", bus.start_infer, 1'b0);

    // Idle command table
    for (int i = 0; i < 7; i++) begin
      s0 = starts;
      bus.infer_busy = vecs[i].busy;
      send(vecs[i].op);
      tick(1);
      $display("vec %0d: op=%0h busy=%0b tx=%0h", i, vecs[i].op, vecs[i].busy, bus.tx_byte);
      check($sformatf("vec%0d_tx", i), bus.tx_byte, vecs[i].exp_tx);
      check($sformatf("vec%0d_starts", i), starts - s0, 0);
    end
    bus.infer_busy = 1'b0;
    check("table_no_writes", wr_seen, 0);

    // Full load 0x00..0x7F
    begin_load();
    for (int i = 0; i < 128; i++) send_data(8'(i));
    finish_load();
    tick(1);
    $display("load: writes=%0d tx=%0h", wr_seen, bus.tx_byte);
    check("load_writes", wr_seen, 128);
    check("load_tx", bus.tx_byte, 8'h80);
    check("load_loaded", bus.img_loaded, 1'b1);

    // Start, busy, done with class 5
    s0 = starts;
    send(8'hA2);
    tick(1);
    check("start_pulses", starts - s0, 1);
    check("start_tx", bus.tx_byte, 8'h80);
    bus.infer_busy = 1'b1;
    tick(3);
    check("busy_tx", bus.tx_byte, 8'hC0);
    bus.infer_busy   = 1'b0;
    bus.infer_done   = 1'b1;
    bus.result_class = 4'h5;
    tick(1);
    bus.infer_done   = 1'b0;
    bus.result_class = 4'h0;
    tick(2);
    $display("infer: tx=%0h", bus.tx_byte);
    check("result_tx", bus.tx_byte, 8'hA5);

    // Reset in the middle of a load
    begin_load();
    for (int i = 0; i < 10; i++) send_data(8'(8'h40 + i));
    tick(1);
    check("midload_tx", bus.tx_byte, 8'h25);
    rst_n = 1'b0;
    #1;
    check("midreset_tx", bus.tx_byte, 8'h00);
    check("midreset_loaded", bus.img_loaded, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Abort by spi_error after 40 bytes, then restart at address 0
    begin_load();
    for (int i = 0; i < 40; i++) send_data(8'(8'hC0 ^ i));
    w0 = wr_seen;
    bus.spi_error = 1'b1;
    tick(1);
    bus.spi_error = 1'b0;
    tick(2);
    $display("abort: tx=%0h", bus.tx_byte);
    check("abort_tx", bus.tx_byte, 8'h10);
    check("abort_loaded", bus.img_loaded, 1'b0);
    begin_load();
    for (int i = 0; i < 128; i++) send_data(8'(8'hFF - i));
    finish_load();
    tick(1);
    check("reload_writes", wr_seen - w0, 128);
    check("reload_tx", bus.tx_byte, 8'h90);
    send(8'hA3);
    tick(1);
    check("clear_tx", bus.tx_byte, 8'h00);

    // byte_valid held for 3 cycles counts as one byte
    begin_load();
    w0 = wr_seen;
    exp_q.push_back({7'd0, 8'h33});
    wr_addr_exp = 7'd1;
    csum        = 8'h33;
    bus.rx_byte    = 8'h33;
    bus.byte_valid = 1'b1;
    tick(3);
    bus.byte_valid = 1'b0;
    tick(2);
    $display("held: writes=%0d", wr_seen - w0);
    check("held_one_write", wr_seen - w0, 1);
    for (int i = 1; i < 128; i++) send_data(8'(i * 3));
    finish_load();
    tick(1);
    check("held_load_tx", bus.tx_byte, 8'h80);

    // START while busy is rejected
    s0 = starts;
    bus.infer_busy = 1'b1;
    send(8'hA2);
    tick(1);
    check("busy_start_pulses", starts - s0, 0);
    check("busy_start_tx", bus.tx_byte, 8'hD0);
    bus.infer_busy = 1'b0;
    send(8'hA3);
    tick(1);
    check("clear2_tx", bus.tx_byte, 8'h00);

`ifdef CHECKSUM_EN
    begin_load();
    for (int i = 0; i < 128; i++) send_data(8'hFF);
    send(8'h00);
    tick(1);
    $display("csum good: tx=%0h", bus.tx_byte);
    check("csum_good_tx", bus.tx_byte, 8'h80);
    begin_load();
    for (int i = 0; i < 128; i++) send_data(8'hFF);
    send(8'h01);
    tick(1);
    $display("csum bad: tx=%0h", bus.tx_byte);
    check("csum_bad_tx", bus.tx_byte, 8'h10);
    check("csum_bad_loaded", bus.img_loaded, 1'b0);
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
